// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding.
package div_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    FIX,
    OUT_Q,
    OUT_R
  } state_t;

endpackage

// File: rtl/div_counter.sv
// Loadable down-counter that tracks the remaining quotient bits.
module div_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  // Next count: load has priority over decrement.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_ld) begin
      w_cnt_nxt = i_ld_val;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Flags the count as it will be after this cycle, so the caller sees the
  // final decrement in the same cycle it happens.
  assign o_zero = (w_cnt_nxt == '0);

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB/FIX
// pass, quotient then remainder streamed on two consecutive done cycles.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_sel,
  output logic [N-1:0] o_result,
  output logic         o_div_by_zero
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N:0]   r_a;
  logic [N-1:0] r_q;
  logic [N-1:0] r_m;
  logic         r_dz;
  logic [N:0]   w_m_ext;
  logic [N:0]   w_diff;
  logic [N:0]   w_sum;
  logic         w_cnt_ld;
  logic         w_cnt_en;
  logic         w_cnt_zero;

  assign w_m_ext  = {1'b0, r_m};
  assign w_diff   = r_a - w_m_ext;
  assign w_sum    = r_a + w_m_ext;
  assign w_cnt_ld = (r_state == LOAD);
  assign w_cnt_en = (r_state == FIX);

  div_counter #(
    .W(CNT_W)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld     (w_cnt_ld),
    .i_ld_val (CNT_W'(N)),
    .i_en     (w_cnt_en),
    .o_zero   (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (r_m == '0) ? OUT_Q : SHIFT;
      SHIFT:   w_state_nxt = SUB;
      SUB:     w_state_nxt = FIX;
      FIX:     w_state_nxt = w_cnt_zero ? OUT_Q : SHIFT;
      OUT_Q:   w_state_nxt = OUT_R;
      OUT_R:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift, trial subtract and restore.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a  <= '0;
      r_q  <= '0;
      r_m  <= '0;
      r_dz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_q <= i_dividend;
            r_m <= i_divisor;
          end
        end
        LOAD: begin
          r_a  <= '0;
          r_dz <= (r_m == '0);
        end
        SHIFT: begin
          r_a <= {r_a[N-1:0], r_q[N-1]};
          r_q <= {r_q[N-2:0], 1'b0};
        end
        SUB: begin
          r_a <= w_diff;
        end
        FIX: begin
          if (r_a[N]) begin
            r_a    <= w_sum;
            r_q[0] <= 1'b0;
          end else begin
            r_q[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; a zero divisor leaves the dividend untouched in Q, which
  // is returned as the remainder.
  always_comb begin
    o_busy        = (r_state != IDLE);
    o_done        = 1'b0;
    o_sel         = 1'b0;
    o_result      = '0;
    o_div_by_zero = 1'b0;
    case (r_state)
      OUT_Q: begin
        o_done        = 1'b1;
        o_result      = r_dz ? '1 : r_q;
        o_div_by_zero = r_dz;
      end
      OUT_R: begin
        o_done        = 1'b1;
        o_sel         = 1'b1;
        o_result      = r_dz ? r_q : r_a[N-1:0];
        o_div_by_zero = r_dz;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks for restoring_divider with a result scoreboard.
module tb_restoring_divider;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic         sel;
  logic [N-1:0] result;
  logic         div_by_zero;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  restoring_divider #(
    .N(N)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_sel         (sel),
    .o_result      (result),
    .o_div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  // Drive a request at a negedge and record its expected result.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
  endtask

  // Wait for the request's done pair, compare against the scoreboard, and
  // end on the first IDLE negedge.
  task automatic collect(input int exp_cyc, input bit hold,
                         output logic [N-1:0] oq, output logic [N-1:0] orr);
    int   cyc;
    bit   got;
    exp_t e;
    got = 1'b0;
    oq  = '0;
    orr = '0;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (cyc == 1) begin
        check("busy_cyc1", 32'(busy), 32'd1);
        check("result_zero_not_done", 32'(result), 32'd0);
        check("dz_zero_not_done", 32'(div_by_zero), 32'd0);
      end
      if (hold) begin
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    if (!got) return;
    check("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (exp_cyc > 0) check("done_cycle", 32'(cyc), 32'(exp_cyc));
    check("q_sel", 32'(sel), 32'd0);
    check("quotient", 32'(result), 32'(e.q));
    check("q_dz", 32'(div_by_zero), 32'(e.dz));
    oq = result;
    if (hold) begin
      dividend = N'($urandom);
      divisor  = N'($urandom);
    end
    @(negedge clk);
    check("r_done", 32'(done), 32'd1);
    check("r_sel", 32'(sel), 32'd1);
    check("remainder", 32'(result), 32'(e.r));
    check("r_dz", 32'(div_by_zero), 32'(e.dz));
    orr = result;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_result", 32'(result), 32'd0);
  endtask

  initial begin
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] a;
    logic [N-1:0] b;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd100, 8'd7);  collect(26, 1'b0, q, r);
    issue(8'd255, 8'd1);  collect(26, 1'b0, q, r);
    issue(8'd5,   8'd9);  collect(26, 1'b0, q, r);
    issue(8'd37,  8'd0);  collect(2,  1'b0, q, r);

    // start held high with changing operands, then back-to-back request
    issue(8'd150, 8'd11); collect(26, 1'b1, q, r);
    issue(8'd60,  8'd6);  collect(26, 1'b0, q, r);

    // reset during SUB of bit 4 (cycle 12 after the start edge)
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    check("async_rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    issue(8'd200, 8'd13); collect(26, 1'b0, q, r);

    for (int i = 0; i < 500; i++) begin
      a = pick();
      b = pick();
      issue(a, b);
      collect((b == 0) ? 2 : 26, 1'b0, q, r);
      if (b != 0) begin
        check("inv_product", 32'(q) * 32'(b) + 32'(r), 32'(a));
        check("inv_rem_lt", 32'(r < b), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
